// File: rtl/serial_adder_controller.sv
// Bit-serial add/subtract unit: one full-adder cell built from two half adders,
// stepped LSB first over WIDTH cycles between valid/ready handshakes.

module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_adder_controller #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             subtract,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] f,
    output logic             carryOut,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    logic s1_s, c1_s, sum_s, c2_s, carry_next_s;

    half_adder u_ha0 (.a_i(opa_q[0]), .b_i(opb_q[0]), .s_o(s1_s),  .c_o(c1_s));
    half_adder u_ha1 (.a_i(s1_s),     .b_i(carry_q),  .s_o(sum_s), .c_o(c2_s));
    assign carry_next_s = c1_s | c2_s;

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        f_d     = f_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (inValid) begin
                    // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
                    opa_d   = a;
                    opb_d   = subtract ? ~b : b;
                    carry_d = subtract;
                    cnt_d   = {CW{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d   = {sum_s, acc_q[WIDTH-1:1]};
                opa_d   = {1'b0, opa_q[WIDTH-1:1]};
                opb_d   = {1'b0, opb_q[WIDTH-1:1]};
                carry_d = carry_next_s;
                if (cnt_q == LAST_BIT) begin
                    ov_d    = carry_q ^ carry_next_s;
                    f_d     = {sum_s, acc_q[WIDTH-1:1]};
                    co_d    = carry_next_s;
                    cnt_d   = {CW{1'b0}};
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                if (outReady) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            opa_q   <= {WIDTH{1'b0}};
            opb_q   <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            f_q     <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign inReady  = (state_q == IDLE);
    assign outValid = (state_q == DONE);
    assign f        = f_q;
    assign carryOut = co_q;
    assign overflow = ov_q;

endmodule

// File: tb/tb_serial_adder_controller.sv
// Directed bench for serial_adder_controller with a queue of expected results.

module tb_serial_adder_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic       inValid;
    logic       inReady;
    logic [7:0] a;
    logic [7:0] b;
    logic       subtract;
    logic       outValid;
    logic       outReady;
    logic [7:0] f;
    logic       carryOut;
    logic       overflow;

    typedef struct {
        logic [7:0] f;
        logic       c;
        logic       v;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_err = 0;

    serial_adder_controller #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .a(a), .b(b), .subtract(subtract), .outValid(outValid),
        .outReady(outReady), .f(f), .carryOut(carryOut), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Independent word-level reference for a +/- b.
    task automatic push_model(input logic [7:0] x, input logic [7:0] y, input logic sub);
        logic [8:0] s;
        exp_t e;
        if (sub) s = {1'b0, x} + {1'b0, ~y} + 9'd1;
        else     s = {1'b0, x} + {1'b0, y};
        e.f = s[7:0];
        e.c = s[8];
        if (sub) e.v = (x[7] != y[7]) && (s[7] != x[7]);
        else     e.v = (x[7] == y[7]) && (s[7] != x[7]);
        exp_q.push_back(e);
    endtask

    task automatic push_exp(input logic [7:0] ef, input logic ec, input logic ev);
        exp_t e;
        e.f = ef; e.c = ec; e.v = ev;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair and wait for the result; optionally scramble inputs during RUN.
    task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic sub);
        int w;
        w = 0;
        while (!inReady && w < 50) begin step(); w++; end
        check("in_ready_before_accept", {31'd0, inReady}, 32'd1);
        a = x; b = y; subtract = sub; inValid = 1'b1;
        step();
        inValid = 1'b0;
    endtask

    task automatic wait_result(input logic scramble);
        int cyc;
        cyc = 0;
        while (!outValid && cyc < 50) begin
            if (scramble) begin
                a = 8'($urandom); b = 8'($urandom); subtract = 1'($urandom);
                inValid = 1'($urandom);
            end
            step();
            cyc++;
        end
        inValid = 1'b0;
        check("latency", cyc, 32'd8);
    endtask

    task automatic check_result(input string tag);
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $error("FAIL %s observed=result expected=empty_scoreboard", tag);
        end else begin
            cur = exp_q.pop_front();
            check({tag, "_f"}, {24'd0, f}, {24'd0, cur.f});
            check({tag, "_carry"}, {31'd0, carryOut}, {31'd0, cur.c});
            check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, cur.v});
        end
    endtask

    task automatic drain();
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        check("in_ready_after_drain", {31'd0, inReady}, 32'd1);
        check("out_valid_after_drain", {31'd0, outValid}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic sub, input logic scramble);
        start_op(x, y, sub);
        wait_result(scramble);
        check_result(tag);
        drain();
    endtask

    initial begin
        reset = 1'b1; inValid = 1'b0; a = 8'h00; b = 8'h00; subtract = 1'b0; outReady = 1'b0;
        #12;
        check("rst_in_ready", {31'd0, inReady}, 32'd1);
        check("rst_out_valid", {31'd0, outValid}, 32'd0);
        check("rst_f", {24'd0, f}, 32'd0);
        check("rst_flags", {30'd0, carryOut, overflow}, 32'd0);
        reset = 1'b0;
        step();

        push_exp(8'h08, 1'b0, 1'b0); run_op("add_5_3", 8'h05, 8'h03, 1'b0, 1'b0);
        push_exp(8'h00, 1'b1, 1'b0); run_op("add_ff_1", 8'hFF, 8'h01, 1'b0, 1'b0);
        push_exp(8'h80, 1'b0, 1'b1); run_op("add_7f_1", 8'h7F, 8'h01, 1'b0, 1'b0);
        push_exp(8'hFE, 1'b0, 1'b0); run_op("sub_3_5", 8'h03, 8'h05, 1'b1, 1'b0);
        push_exp(8'h7F, 1'b1, 1'b1); run_op("sub_80_1", 8'h80, 8'h01, 1'b1, 1'b0);
        push_exp(8'h00, 1'b1, 1'b0); run_op("sub_5_5", 8'h05, 8'h05, 1'b1, 1'b0);

        // Back-pressure: result must hold while new operand pulses are ignored.
        push_model(8'hC3, 8'h5A, 1'b0);
        start_op(8'hC3, 8'h5A, 1'b0);
        wait_result(1'b0);
        check_result("bp_first");
        for (int i = 0; i < 5; i++) begin
            a = 8'(i * 37); b = 8'(i * 11 + 1); subtract = 1'(i); inValid = 1'b1;
            step();
            check("bp_out_valid", {31'd0, outValid}, 32'd1);
            check("bp_in_ready", {31'd0, inReady}, 32'd0);
            check("bp_f_hold", {24'd0, f}, {24'd0, cur.f});
            check("bp_flags_hold", {30'd0, carryOut, overflow}, {30'd0, cur.c, cur.v});
        end
        inValid = 1'b0;
        drain();
        step();
        check("bp_no_stray_accept", {31'd0, inReady}, 32'd1);

        // Operand hold: inputs change every RUN cycle.
        push_model(8'h9C, 8'h27, 1'b1); run_op("hold_sub", 8'h9C, 8'h27, 1'b1, 1'b1);
        push_model(8'h6E, 8'hB1, 1'b0); run_op("hold_add", 8'h6E, 8'hB1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] x, y;
            logic s;
            x = 8'($urandom); y = 8'($urandom); s = 1'($urandom);
            push_model(x, y, s);
            run_op("rand", x, y, s, 1'b0);
        end

        // Reset on the 4th RUN cycle aborts the operation; last result is nonzero here.
        push_exp(8'hFF, 1'b0, 1'b0); run_op("pre_abort", 8'hF0, 8'h0F, 1'b0, 1'b0);
        start_op(8'h55, 8'h22, 1'b0);
        step(); step(); step();
        check("abort_still_busy", {31'd0, inReady}, 32'd0);
        reset = 1'b1;
        #1;
        check("abort_out_valid", {31'd0, outValid}, 32'd0);
        check("abort_in_ready", {31'd0, inReady}, 32'd1);
        check("abort_f", {24'd0, f}, 32'd0);
        check("abort_flags", {30'd0, carryOut, overflow}, 32'd0);
        reset = 1'b0;
        step();
        push_exp(8'h46, 1'b0, 1'b0); run_op("post_abort", 8'h12, 8'h34, 1'b0, 1'b0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_adder_controller.md
# serial_adder_controller

Bit-serial add/subtract unit that sequences a single 1-bit full-adder cell over WIDTH clock cycles, LSB first. The cell is two HalfAdder instances plus an OR for the carry. The block accepts an operand pair over a valid/ready handshake, holds a carry flip-flop between bit steps, and returns the WIDTH-bit result with carry and signed-overflow flags over a second valid/ready handshake. It is the area-minimal arithmetic path of the APU, for use where a parallel WIDTH-bit adder is not justified.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- inValid  in  1  operand pair and mode present.
- inReady  out  1  block can accept operands (high only in IDLE).
- a  in  WIDTH  operand 1, unsigned or two's complement.
- b  in  WIDTH  operand 2.
- subtract  in  1  0: f = a + b; 1: f = a - b.
- outValid  out  1  result valid (high only in DONE).
- outReady  in  1  consumer accepts result.
- f  out  WIDTH  result.
- carryOut  out  1  carry out of MSB. For subtract it is the not-borrow flag (1 when a >= b unsigned).
- overflow  out  1  signed overflow.

## Operation
- States are IDLE, RUN and DONE. Moore outputs: inReady = (state == IDLE) and outValid = (state == DONE).
- **IDLE**
  - Accept when inValid & inReady.
  - On accept, capture opA = a and opB = subtract ? ~b : b, set carry = subtract, set bitCount = 0, and go to RUN.
- **RUN**, once per cycle:
  - sum = opA[0] ^ opB[0] ^ carry, computed as HalfAdder(opA[0], opB[0]) followed by HalfAdder(s1, carry).
  - carryNext = c1 | c2.
  - Shift the accumulator right with sum inserted at bit WIDTH-1. Shift opA and opB right by 1.
  - carry <= carryNext and bitCount <= bitCount + 1.
  - On the step where bitCount == WIDTH-1 (the MSB step):
    - latch overflow = carry (carry into MSB) ^ carryNext;
    - load f from the final accumulator value including this step's sum bit;
    - set carryOut = carryNext;
    - go to DONE.
- **DONE**: f, carryOut and overflow are held stable. On outValid & outReady, go to IDLE.
- f, carryOut and overflow change only on the MSB step. They keep the last result through IDLE and RUN of the next operation.
- a, b, subtract and inValid are ignored outside IDLE. outReady is ignored outside DONE.
- bitCount is $clog2(WIDTH) bits wide. It never wraps, because it leaves RUN at WIDTH-1.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, so inReady = 1 and outValid = 0;
  - f = 0, carryOut = 0, overflow = 0;
  - opA, opB, carry, bitCount and the accumulator are all 0.
- Reset asserted during RUN or DONE aborts the operation. No result is produced, and the first accept after reset deasserts is processed normally.
- Let E0 be the accept edge. RUN occupies the cycles after E0 through edge E_WIDTH.
- outValid rises after edge E_WIDTH, so latency is WIDTH cycles from accept to outValid.
- The output handshake completes at edge Ed. inReady is high the cycle after Ed.
- Back-to-back throughput is one result per WIDTH+2 cycles, assuming outReady is held high.
- No combinational path from inputs to outputs; all outputs are registered or decoded from state.

## Test plan
1. **Add, no carry.** WIDTH=8, a=0x05, b=0x03, subtract=0. Expect f=0x08, carryOut=0, overflow=0. outValid is high exactly 8 cycles after the accept edge.
2. **Unsigned wrap and signed overflow, add.**
   - 0xFF + 0x01: expect f=0x00, carryOut=1, overflow=0.
   - 0x7F + 0x01: expect f=0x80, carryOut=0, overflow=1.
3. **Subtract.**
   - 0x03 - 0x05: expect f=0xFE, carryOut=0, overflow=0.
   - 0x80 - 0x01: expect f=0x7F, carryOut=1, overflow=1.
   - 0x05 - 0x05: expect f=0x00, carryOut=1.
4. **Back-pressure.** Hold outReady=0 for 5 cycles in DONE while pulsing inValid with new operands.
   - outValid, f and flags stay stable, inReady stays 0, and the pulses are ignored.
   - Then set outReady=1: the state is IDLE the next cycle.
5. **Operand hold.** Change a and b every cycle during RUN. The result matches only the values captured at accept.
6. **Reset mid-operation.** Assert reset on the 4th RUN cycle.
   - Immediately: outValid=0, inReady=1, f=0.
   - After release, a 0x12 + 0x34 run gives f=0x46 with no residue from the aborted run.
